// File: rtl/vga_timing_ctrl.sv
// Raster timing generator for the pixel datapath: scans the active area, lines the
// sync/blank controls up with the draw-logic latency, and registers the VGA pins.
module vga_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   PIX_LAT  = 2,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_valid,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic       frame_start,
    output logic       line_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {ST_ACTIVE, ST_FP, ST_SYNC, ST_BP} seg_e;

    typedef struct packed {
        logic blank_n;
        logic hsync;
        logic vsync;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{blank_n: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL};

    // Segment a counter value falls into; later segments win so zero-width porches collapse.
    function automatic seg_e seg_of(input logic [9:0] c, input int act, input int fp, input int sy);
        if (int'(c) >= act + fp + sy) return ST_BP;
        if (int'(c) >= act + fp)      return ST_SYNC;
        if (int'(c) >= act)           return ST_FP;
        return ST_ACTIVE;
    endfunction

    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    seg_e       h_st, v_st, h_st_nxt, v_st_nxt;
    logic       h_wrap, v_wrap, started, act;
    ctl_t       raw, tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_st    <= ST_ACTIVE;
            v_st    <= ST_ACTIVE;
            started <= 1'b0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            h_st  <= h_st_nxt;
            v_st  <= v_st_nxt;
            if (en) started <= 1'b1;
        end
    end

    always_comb begin
        h_wrap   = (h_cnt == 10'(H_TOTAL - 1));
        v_wrap   = (v_cnt == 10'(V_TOTAL - 1));
        h_nxt    = h_cnt;
        v_nxt    = v_cnt;
        h_st_nxt = h_st;
        v_st_nxt = v_st;
        if (en) begin
            h_nxt    = h_wrap ? '0 : h_cnt + 10'd1;
            h_st_nxt = seg_of(h_nxt, H_ACTIVE, H_FP, H_SYNC);
            if (h_wrap) begin
                v_nxt    = v_wrap ? '0 : v_cnt + 10'd1;
                v_st_nxt = seg_of(v_nxt, V_ACTIVE, V_FP, V_SYNC);
            end
        end
    end

    // Raw region flag ignores 'started' so pixel (0,0) of the first frame is not blanked.
    assign act         = (h_st == ST_ACTIVE) && (v_st == ST_ACTIVE);
    assign pixel_valid = started && act;
    assign pixel_x     = act ? h_cnt : '0;
    assign pixel_y     = act ? v_cnt : '0;
    assign line_start  = en && h_wrap;
    assign frame_start = en && h_wrap && v_wrap;

    assign raw.blank_n = act;
    assign raw.hsync   = (h_st == ST_SYNC) ? HS_POL : ~HS_POL;
    assign raw.vsync   = (v_st == ST_SYNC) ? VS_POL : ~VS_POL;

    generate
        if (PIX_LAT == 0) begin : g_nodly
            assign tail = raw;
        end else begin : g_dly
            ctl_t dl [PIX_LAT];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < PIX_LAT; i++) dl[i] <= CTL_IDLE;
                end else if (en) begin
                    dl[0] <= raw;
                    for (int i = 1; i < PIX_LAT; i++) dl[i] <= dl[i-1];
                end
            end
            assign tail = dl[PIX_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= ~HS_POL;
            vga_vsync   <= ~VS_POL;
            vga_blank_n <= 1'b0;
        end else if (en) begin
            vga_r       <= tail.blank_n ? in_r : '0;
            vga_g       <= tail.blank_n ? in_g : '0;
            vga_b       <= tail.blank_n ? in_b : '0;
            vga_hsync   <= tail.hsync;
            vga_vsync   <= tail.vsync;
            vga_blank_n <= tail.blank_n;
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size 640x480 instance and a tiny-raster instance
// (zero latency, positive hsync) checked every clock against an arithmetic raster model.
module tb_vga_timing_ctrl;
    typedef struct packed {
        int   ha, hf, hs, hb, va, vf, vs, vb, lat;
        logic hp, vp;
    } tim_t;

    typedef struct packed {
        logic [9:0] px, py;
        logic       pv, ls, fs;
        logic [7:0] r, g, b;
        logic       hs, vs, bn;
    } exp_t;

    localparam tim_t TA = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
                            lat: 2, hp: 1'b0, vp: 1'b0};
    localparam tim_t TB = '{ha: 16, hf: 4, hs: 6, hb: 6, va: 12, vf: 3, vs: 2, vb: 4,
                            lat: 0, hp: 1'b1, vp: 1'b0};

    logic clk = 1'b0;
    logic rst, en, ff;
    logic [7:0] in_r_a, in_g_a, in_b_a, in_r_b, in_g_b, in_b_b;
    logic [9:0] px_a, py_a, px_b, py_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic pv_a, hs_a, vs_a, bn_a, fs_a, ls_a;
    logic pv_b, hs_b, vs_b, bn_b, fs_b, ls_b;
    int ticks = 0;
    int checks = 0, passes = 0, phase = 0;
    int first_hs = -1, hs_run = 0, ls_cnt = 0, fs_cnt = 0, bn_cnt = 0, vs_cnt = 0;
    exp_t act_a, act_b;

    always #5 clk = ~clk;

    vga_timing_ctrl #(.H_ACTIVE(TA.ha), .H_FP(TA.hf), .H_SYNC(TA.hs), .H_BP(TA.hb),
                      .V_ACTIVE(TA.va), .V_FP(TA.vf), .V_SYNC(TA.vs), .V_BP(TA.vb),
                      .PIX_LAT(TA.lat), .HS_POL(TA.hp), .VS_POL(TA.vp)) dut_a (
        .clk(clk), .rst(rst), .en(en), .pixel_x(px_a), .pixel_y(py_a), .pixel_valid(pv_a),
        .in_r(in_r_a), .in_g(in_g_a), .in_b(in_b_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_blank_n(bn_a),
        .frame_start(fs_a), .line_start(ls_a));

    vga_timing_ctrl #(.H_ACTIVE(TB.ha), .H_FP(TB.hf), .H_SYNC(TB.hs), .H_BP(TB.hb),
                      .V_ACTIVE(TB.va), .V_FP(TB.vf), .V_SYNC(TB.vs), .V_BP(TB.vb),
                      .PIX_LAT(TB.lat), .HS_POL(TB.hp), .VS_POL(TB.vp)) dut_b (
        .clk(clk), .rst(rst), .en(en), .pixel_x(px_b), .pixel_y(py_b), .pixel_valid(pv_b),
        .in_r(in_r_b), .in_g(in_g_b), .in_b(in_b_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_blank_n(bn_b),
        .frame_start(fs_b), .line_start(ls_b));

    assign act_a = {px_a, py_a, pv_a, ls_a, fs_a, r_a, g_a, b_a, hs_a, vs_a, bn_a};
    assign act_b = {px_b, py_b, pv_b, ls_b, fs_b, r_b, g_b, b_b, hs_b, vs_b, bn_b};

    // En-ticks since the last reset release; the whole model is a function of this count.
    always @(posedge clk or negedge rst)
        if (!rst) ticks <= 0;
        else if (en) ticks <= ticks + 1;

    function automatic int htot(tim_t t); return t.ha + t.hf + t.hs + t.hb; endfunction
    function automatic int vtot(tim_t t); return t.va + t.vf + t.vs + t.vb; endfunction

    function automatic void pos(tim_t t, int n, output int h, output int v);
        int c = n % (htot(t) * vtot(t));
        h = c % htot(t);
        v = c / htot(t);
    endfunction

    // Expected outputs after n en-ticks; vga_* show the coordinate of tick n-1-lat.
    function automatic exp_t model(tim_t t, int n, logic e, logic f);
        int h, v, k;
        exp_t x = '0;
        pos(t, n, h, v);
        if (h < t.ha && v < t.va) begin
            x.px = 10'(h);
            x.py = 10'(v);
            x.pv = (n > 0);
        end
        x.ls = e && (h == htot(t) - 1);
        x.fs = x.ls && (v == vtot(t) - 1);
        x.hs = ~t.hp;
        x.vs = ~t.vp;
        k = n - 1 - t.lat;
        if (k >= 0) begin
            pos(t, k, h, v);
            if (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) x.hs = t.hp;
            if (v >= t.va + t.vf && v < t.va + t.vf + t.vs) x.vs = t.vp;
            if (h < t.ha && v < t.va) begin
                x.bn = 1'b1;
                x.r  = f ? 8'hFF : 8'(h);
                x.g  = f ? 8'hFF : 8'(v);
                x.b  = f ? 8'hFF : 8'hA5;
            end
        end
        return x;
    endfunction

    // Draw-logic stand-in: returns the colour of the coordinate presented lat ticks earlier.
    function automatic logic [23:0] stim(tim_t t, int n, logic f);
        int h, v;
        if (f) return 24'hFFFFFF;
        if (n - t.lat < 0) return 24'h0000A5;
        pos(t, n - t.lat, h, v);
        return {8'(h), 8'(v), 8'hA5};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h (tick %0d, t=%0t)", nm, act, exp, ticks, $time);
    endtask

    task automatic cmp(input string tag, input exp_t a, input exp_t e);
        chk({tag, ".pixel_x"}, 32'(a.px), 32'(e.px));
        chk({tag, ".pixel_y"}, 32'(a.py), 32'(e.py));
        chk({tag, ".pixel_valid"}, 32'(a.pv), 32'(e.pv));
        chk({tag, ".line_start"}, 32'(a.ls), 32'(e.ls));
        chk({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
        chk({tag, ".vga_r"}, 32'(a.r), 32'(e.r));
        chk({tag, ".vga_g"}, 32'(a.g), 32'(e.g));
        chk({tag, ".vga_b"}, 32'(a.b), 32'(e.b));
        chk({tag, ".vga_hsync"}, 32'(a.hs), 32'(e.hs));
        chk({tag, ".vga_vsync"}, 32'(a.vs), 32'(e.vs));
        chk({tag, ".vga_blank_n"}, 32'(a.bn), 32'(e.bn));
    endtask

    always @(negedge clk) begin
        cmp("a", act_a, model(TA, ticks, en, ff));
        cmp("b", act_b, model(TB, ticks, en, ff));
    end

    // Raw event tallies from the first full-rate run, pinned against literals at the end.
    always @(negedge clk) begin
        if (phase == 1) begin
            if (!hs_a && ticks < 800) begin
                if (first_hs < 0) first_hs = ticks;
                hs_run++;
            end
            if (ls_a) ls_cnt++;
            if (fs_b) fs_cnt++;
            if (ticks >= 100 && ticks < 772) begin
                if (bn_b) bn_cnt++;
                if (!vs_b) vs_cnt++;
            end
        end
    end

    task automatic step(input logic e);
        en = e;
        {in_r_a, in_g_a, in_b_a} = stim(TA, ticks, ff);
        {in_r_b, in_g_b, in_b_b} = stim(TB, ticks, ff);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input logic f);
        rst = 1'b0;
        ff  = f;
        step(1'b0);
        step(1'b0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        ff  = 1'b0;
        {in_r_a, in_g_a, in_b_a, in_r_b, in_g_b, in_b_b} = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.a.hsync", 32'(hs_a), 32'd1);
        chk("rst.a.blank_n", 32'(bn_a), 32'd0);
        chk("rst.b.hsync", 32'(hs_b), 32'd0);
        chk("rst.b.vsync", 32'(vs_b), 32'd1);
        rst   = 1'b1;

        // Full rate from reset.
        phase = 1;
        for (int i = 0; i < 1700; i++) begin
            step(1'b1);
            if (ticks == 8) begin
                chk("lit.a.r_col5", 32'(r_a), 32'd5);
                chk("lit.b.r_col7", 32'(r_b), 32'd7);
            end
        end
        phase = 0;
        chk("lit.a.hsync_first", 32'(first_hs), 32'd659);
        chk("lit.a.hsync_width", 32'(hs_run), 32'd96);
        chk("lit.a.line_starts", 32'(ls_cnt), 32'd2);
        chk("lit.b.frame_starts", 32'(fs_cnt), 32'd2);
        chk("lit.b.blank_hi_per_frame", 32'(bn_cnt), 32'd192);
        chk("lit.b.vsync_lo_per_frame", 32'(vs_cnt), 32'd64);

        // Half rate: en alternates, outputs must hold on idle clocks.
        reset_pulse(1'b0);
        for (int i = 0; i < 3400; i++) step(i % 2 == 0);

        // Asynchronous reset mid-line at (300,1) on the full-size raster.
        reset_pulse(1'b0);
        repeat (1100) step(1'b1);
        chk("lit.a.pre_rst_x", 32'(px_a), 32'd300);
        rst = 1'b0;
        #1;
        chk("lit.a.async_x", 32'(px_a), 32'd0);
        chk("lit.a.async_r", 32'(r_a), 32'd0);
        chk("lit.a.async_hsync", 32'(hs_a), 32'd1);
        chk("lit.a.async_blank_n", 32'(bn_a), 32'd0);
        chk("lit.b.async_hsync", 32'(hs_b), 32'd0);
        repeat (3) step(1'b1);
        rst = 1'b1;
        repeat (900) step(1'b1);

        // Constant white from the draw logic: blanking alone decides the colour.
        reset_pulse(1'b1);
        repeat (1700) step(1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
